// File: rtl/vscale_mem_arbiter_pkg.sv
// Shared encodings for the two-master HASTI arbiter: bus constants,
// port FSM states and data-phase owner identifiers.
package vscale_mem_arbiter_pkg;

    localparam int HASTI_ADDR_WIDTH = 32;
    localparam int HASTI_BUS_WIDTH  = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_WORD    = 3'd2;
    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [1:0] {
        M_IDLE = 2'd0,
        M_PEND = 2'd1,
        M_DATA = 2'd2
    } mstate_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IMEM = 2'd1,
        OWN_DMEM = 2'd2
    } owner_e;

endpackage

// File: rtl/vscale_mem_arbiter_if.sv
// One HASTI (AHB-Lite) link; the same bundle serves both master ports
// and the slave port of the arbiter.
interface vscale_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32
);
    logic [ADDR_WIDTH-1:0] haddr;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [1:0]            htrans;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic                  hmastlock;
    logic [BUS_WIDTH-1:0]  hwdata;
    logic [BUS_WIDTH-1:0]  hrdata;
    logic                  hready;
    logic                  hresp;

    modport master (
        output haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, htrans, hburst, hprot, hmastlock, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/vscale_arb_port.sv
// Per-master port: IDLE/PEND/DATA state machine plus a one-deep address
// buffer that holds an address phase the arbiter could not grant.
import vscale_mem_arbiter_pkg::*;

module vscale_arb_port #(
    parameter int ADDR_WIDTH = HASTI_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            htrans_i,
    input  logic [ADDR_WIDTH-1:0] haddr_i,
    input  logic                  hwrite_i,
    input  logic [2:0]            hsize_i,
    input  logic                  grant_i,
    input  logic                  s_hready_i,
    output logic                  hready_o,
    output logic                  req_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic                  hwrite_o,
    output logic [2:0]            hsize_o
);

    mstate_e               state_q, state_d;
    logic [ADDR_WIDTH-1:0] haddr_q;
    logic                  hwrite_q;
    logic [2:0]            hsize_q;
    logic                  live;
    logic                  capture;

    always_comb begin
        hready_o = 1'b1;
        case (state_q)
            M_IDLE:  hready_o = 1'b1;
            M_PEND:  hready_o = 1'b0;
            M_DATA:  hready_o = s_hready_i;
            default: hready_o = 1'b1;
        endcase
    end

    assign live    = (htrans_i == HTRANS_NONSEQ) && hready_o;
    assign req_o   = live || (state_q == M_PEND);
    assign capture = live && !grant_i;

    // A pending master always replays its buffered address, never the live bus.
    assign haddr_o  = (state_q == M_PEND) ? haddr_q  : haddr_i;
    assign hwrite_o = (state_q == M_PEND) ? hwrite_q : hwrite_i;
    assign hsize_o  = (state_q == M_PEND) ? hsize_q  : hsize_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            M_IDLE: begin
                if (live) state_d = grant_i ? M_DATA : M_PEND;
            end
            M_PEND: begin
                if (grant_i) state_d = M_DATA;
            end
            M_DATA: begin
                if (s_hready_i) begin
                    if (live) state_d = grant_i ? M_DATA : M_PEND;
                    else      state_d = M_IDLE;
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= M_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            haddr_q  <= haddr_i;
            hwrite_q <= hwrite_i;
            hsize_q  <= hsize_i;
        end
    end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// Lets the instruction and data master ports of vscale_core share one
// HASTI slave: round-robin grant, data-phase owner tracking and muxing.
import vscale_mem_arbiter_pkg::*;

module vscale_mem_arbiter #(
    parameter int ADDR_WIDTH = HASTI_ADDR_WIDTH,
    parameter int BUS_WIDTH  = HASTI_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    vscale_mem_arbiter_if.slave  im,
    vscale_mem_arbiter_if.slave  dm,
    vscale_mem_arbiter_if.master s
);

    logic                  im_req, dm_req;
    logic                  im_grant, dm_grant;
    logic                  im_hready, dm_hready;
    logic [ADDR_WIDTH-1:0] im_addr, dm_addr;
    logic                  im_write, dm_write;
    logic [2:0]            im_size, dm_size;
    logic                  arb_en;

    owner_e                last_grant_q, last_grant_d;
    owner_e                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;

    logic                  unused_sideband;

    vscale_arb_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_im_port (
        .clk        (clk),
        .reset      (reset),
        .htrans_i   (im.htrans),
        .haddr_i    (im.haddr),
        .hwrite_i   (im.hwrite),
        .hsize_i    (im.hsize),
        .grant_i    (im_grant),
        .s_hready_i (s.hready),
        .hready_o   (im_hready),
        .req_o      (im_req),
        .haddr_o    (im_addr),
        .hwrite_o   (im_write),
        .hsize_o    (im_size)
    );

    vscale_arb_port #(.ADDR_WIDTH(ADDR_WIDTH)) u_dm_port (
        .clk        (clk),
        .reset      (reset),
        .htrans_i   (dm.htrans),
        .haddr_i    (dm.haddr),
        .hwrite_i   (dm.hwrite),
        .hsize_i    (dm.hsize),
        .grant_i    (dm_grant),
        .s_hready_i (s.hready),
        .hready_o   (dm_hready),
        .req_o      (dm_req),
        .haddr_o    (dm_addr),
        .hwrite_o   (dm_write),
        .hsize_o    (dm_size)
    );

    // Reset gates the grant so nothing is issued while state is being cleared.
    assign arb_en = s.hready && !reset;

    always_comb begin
        im_grant = 1'b0;
        dm_grant = 1'b0;
        if (arb_en) begin
            if (im_req && dm_req) begin
                if (last_grant_q == OWN_IMEM) dm_grant = 1'b1;
                else                          im_grant = 1'b1;
            end else begin
                im_grant = im_req;
                dm_grant = dm_req;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        if (im_grant) begin
            last_grant_d = OWN_IMEM;
            haddr_d      = im_addr;
            hwrite_d     = im_write;
            hsize_d      = im_size;
        end else if (dm_grant) begin
            last_grant_d = OWN_DMEM;
            haddr_d      = dm_addr;
            hwrite_d     = dm_write;
            hsize_d      = dm_size;
        end
        if (s.hready) begin
            if (im_grant)      owner_d = OWN_IMEM;
            else if (dm_grant) owner_d = OWN_DMEM;
            else               owner_d = OWN_NONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= OWN_IMEM;
            owner_q      <= OWN_NONE;
            haddr_q      <= '0;
            hwrite_q     <= 1'b0;
            hsize_q      <= 3'd0;
        end else begin
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            haddr_q      <= haddr_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
        end
    end

    assign s.htrans    = (im_grant || dm_grant) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign s.haddr     = haddr_d;
    assign s.hwrite    = hwrite_d;
    assign s.hsize     = hsize_d;
    assign s.hburst    = HBURST_SINGLE;
    assign s.hprot     = HPROT_DEFAULT;
    assign s.hmastlock = 1'b0;

    always_comb begin
        s.hwdata = '0;
        case (owner_q)
            OWN_IMEM: s.hwdata = im.hwdata;
            OWN_DMEM: s.hwdata = dm.hwdata;
            default:  s.hwdata = '0;
        endcase
    end

    assign im.hrdata = s.hrdata;
    assign dm.hrdata = s.hrdata;
    assign im.hready = im_hready;
    assign dm.hready = dm_hready;
    assign im.hresp  = (owner_q == OWN_IMEM) ? s.hresp : HRESP_OKAY;
    assign dm.hresp  = (owner_q == OWN_DMEM) ? s.hresp : HRESP_OKAY;

    // Masters' burst/protection attributes are replaced by fixed values.
    assign unused_sideband = ^{im.hburst, im.hprot, im.hmastlock,
                               dm.hburst, dm.hprot, dm.hmastlock};

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Directed bench for vscale_mem_arbiter: the bench plays both masters and
// the slave cycle by cycle and compares against hand-derived values.
import vscale_mem_arbiter_pkg::*;

module tb_vscale_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    vscale_mem_arbiter_if im_bus ();
    vscale_mem_arbiter_if dm_bus ();
    vscale_mem_arbiter_if s_bus ();

    vscale_mem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .im    (im_bus),
        .dm    (dm_bus),
        .s     (s_bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic im_drive(input logic [1:0] tr, input logic [31:0] a, input logic w);
        im_bus.htrans = tr;
        im_bus.haddr  = a;
        im_bus.hwrite = w;
    endtask

    task automatic dm_drive(input logic [1:0] tr, input logic [31:0] a, input logic w);
        dm_bus.htrans = tr;
        dm_bus.haddr  = a;
        dm_bus.hwrite = w;
    endtask

    logic [31:0] im_addrs [4];
    logic [31:0] dm_addrs [4];
    logic [31:0] exp_sa   [8];
    logic [31:0] im_rx    [4];
    logic [31:0] dm_rx    [4];
    int          ik, dk, im_rx_n, dm_rx_n;
    bit          im_out, dm_out;

    initial begin
        im_addrs = '{32'h300, 32'h304, 32'h308, 32'h30C};
        dm_addrs = '{32'h400, 32'h404, 32'h408, 32'h40C};
        exp_sa   = '{32'h400, 32'h300, 32'h404, 32'h304,
                     32'h408, 32'h308, 32'h40C, 32'h30C};

        reset = 1'b1;
        im_drive(HTRANS_IDLE, 32'h0, 1'b0);
        dm_drive(HTRANS_IDLE, 32'h0, 1'b0);
        im_bus.hsize = HSIZE_WORD;  dm_bus.hsize = HSIZE_WORD;
        im_bus.hwdata = '0;         dm_bus.hwdata = '0;
        im_bus.hburst = 3'd0;       dm_bus.hburst = 3'd0;
        im_bus.hprot = 4'b0011;     dm_bus.hprot = 4'b0011;
        im_bus.hmastlock = 1'b0;    dm_bus.hmastlock = 1'b0;
        s_bus.hrdata = '0;
        s_bus.hready = 1'b1;
        s_bus.hresp  = HRESP_OKAY;
        tick();
        tick();

        // Reset state
        reset = 1'b0;
        #2;
        check_val("rst_im_hready", im_bus.hready, 1);
        check_val("rst_dm_hready", dm_bus.hready, 1);
        check_val("rst_im_hresp", im_bus.hresp, HRESP_OKAY);
        check_val("rst_dm_hresp", dm_bus.hresp, HRESP_OKAY);
        check_val("rst_s_htrans", s_bus.htrans, HTRANS_IDLE);
        check_val("rst_s_haddr", s_bus.haddr, 0);
        check_val("rst_s_hwrite", s_bus.hwrite, 0);
        check_val("rst_s_hsize", s_bus.hsize, 0);
        tick();

        // Lone instruction fetch
        im_drive(HTRANS_NONSEQ, 32'h100, 1'b0);
        #2;
        check_val("t1_s_htrans", s_bus.htrans, HTRANS_NONSEQ);
        check_val("t1_s_haddr", s_bus.haddr, 32'h100);
        check_val("t1_s_hsize", s_bus.hsize, HSIZE_WORD);
        check_val("t1_s_hburst", s_bus.hburst, HBURST_SINGLE);
        check_val("t1_s_hprot", s_bus.hprot, 4'b0011);
        check_val("t1_dm_hready_a", dm_bus.hready, 1);
        tick();
        im_drive(HTRANS_IDLE, 32'h0, 1'b0);
        s_bus.hrdata = 32'hDEADBEEF;
        #2;
        check_val("t1_im_hrdata", im_bus.hrdata, 32'hDEADBEEF);
        check_val("t1_im_hready", im_bus.hready, 1);
        check_val("t1_dm_hready_d", dm_bus.hready, 1);
        check_val("t1_s_htrans_idle", s_bus.htrans, HTRANS_IDLE);
        check_val("t1_s_haddr_hold", s_bus.haddr, 32'h100);
        tick();
        s_bus.hrdata = '0;

        // Simultaneous conflict: dm wins first
        im_drive(HTRANS_NONSEQ, 32'h100, 1'b0);
        dm_drive(HTRANS_NONSEQ, 32'h200, 1'b1);
        #2;
        check_val("t2_s_haddr_dm", s_bus.haddr, 32'h200);
        check_val("t2_s_hwrite_dm", s_bus.hwrite, 1);
        check_val("t2_s_htrans_a", s_bus.htrans, HTRANS_NONSEQ);
        tick();
        im_drive(HTRANS_IDLE, 32'h0, 1'b0);
        dm_drive(HTRANS_IDLE, 32'h0, 1'b0);
        dm_bus.hwdata = 32'hCAFE0200;
        im_bus.hwdata = 32'h11111111;
        #2;
        check_val("t2_im_hready_stall", im_bus.hready, 0);
        check_val("t2_dm_hready", dm_bus.hready, 1);
        check_val("t2_s_hwdata_dm", s_bus.hwdata, 32'hCAFE0200);
        check_val("t2_s_haddr_im", s_bus.haddr, 32'h100);
        check_val("t2_s_hwrite_im", s_bus.hwrite, 0);
        check_val("t2_s_htrans_b", s_bus.htrans, HTRANS_NONSEQ);
        tick();
        s_bus.hrdata = 32'h12340100;
        #2;
        check_val("t2_im_hready_data", im_bus.hready, 1);
        check_val("t2_im_hrdata", im_bus.hrdata, 32'h12340100);
        check_val("t2_s_hwdata_im", s_bus.hwdata, 32'h11111111);
        check_val("t2_s_htrans_c", s_bus.htrans, HTRANS_IDLE);
        tick();
        dm_bus.hwdata = '0;
        im_bus.hwdata = '0;

        // Sustained contention: 4 transfers per master
        ik = 0; dk = 0; im_rx_n = 0; dm_rx_n = 0; im_out = 0; dm_out = 0;
        for (int c = 0; c < 10; c++) begin
            if (ik < 4) im_drive(HTRANS_NONSEQ, im_addrs[ik], 1'b0);
            else        im_drive(HTRANS_IDLE, 32'h0, 1'b0);
            if (dk < 4) dm_drive(HTRANS_NONSEQ, dm_addrs[dk], 1'b0);
            else        dm_drive(HTRANS_IDLE, 32'h0, 1'b0);
            s_bus.hrdata = 32'hA5A50000 | 32'(c);
            #2;
            if (c < 8) begin
                check_val($sformatf("t3_s_htrans_%0d", c), s_bus.htrans, HTRANS_NONSEQ);
                check_val($sformatf("t3_s_haddr_%0d", c), s_bus.haddr, exp_sa[c]);
            end else begin
                check_val($sformatf("t3_s_htrans_%0d", c), s_bus.htrans, HTRANS_IDLE);
            end
            if (im_bus.hready) begin
                if (im_out && im_rx_n < 4) begin
                    im_rx[im_rx_n] = im_bus.hrdata;
                    im_rx_n++;
                end
                im_out = (im_bus.htrans == HTRANS_NONSEQ);
                if (im_out) ik++;
            end
            if (dm_bus.hready) begin
                if (dm_out && dm_rx_n < 4) begin
                    dm_rx[dm_rx_n] = dm_bus.hrdata;
                    dm_rx_n++;
                end
                dm_out = (dm_bus.htrans == HTRANS_NONSEQ);
                if (dm_out) dk++;
            end
            tick();
        end
        check_val("t3_im_rx_count", im_rx_n, 4);
        check_val("t3_dm_rx_count", dm_rx_n, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < im_rx_n)
                check_val($sformatf("t3_im_rx_%0d", i), im_rx[i], 32'hA5A50000 | 32'(2 + 2 * i));
            if (i < dm_rx_n)
                check_val($sformatf("t3_dm_rx_%0d", i), dm_rx[i], 32'hA5A50000 | 32'(1 + 2 * i));
        end
        s_bus.hrdata = '0;

        // Slave wait states with im buffered behind them
        dm_drive(HTRANS_NONSEQ, 32'h500, 1'b0);
        #2;
        check_val("t4_s_haddr_dm", s_bus.haddr, 32'h500);
        tick();
        dm_drive(HTRANS_IDLE, 32'h0, 1'b0);
        im_drive(HTRANS_NONSEQ, 32'h104, 1'b0);
        s_bus.hready = 1'b0;
        #2;
        check_val("t4_s_htrans_w0", s_bus.htrans, HTRANS_IDLE);
        check_val("t4_dm_hready_w0", dm_bus.hready, 0);
        check_val("t4_im_hready_w0", im_bus.hready, 1);
        tick();
        im_drive(HTRANS_IDLE, 32'hBAD0, 1'b1);
        for (int w = 1; w < 3; w++) begin
            #2;
            check_val($sformatf("t4_s_htrans_w%0d", w), s_bus.htrans, HTRANS_IDLE);
            check_val($sformatf("t4_im_hready_w%0d", w), im_bus.hready, 0);
            check_val($sformatf("t4_dm_hready_w%0d", w), dm_bus.hready, 0);
            tick();
        end
        s_bus.hready = 1'b1;
        s_bus.hrdata = 32'h5555AAAA;
        #2;
        check_val("t4_dm_hready_end", dm_bus.hready, 1);
        check_val("t4_dm_hrdata", dm_bus.hrdata, 32'h5555AAAA);
        check_val("t4_s_htrans_replay", s_bus.htrans, HTRANS_NONSEQ);
        check_val("t4_s_haddr_replay", s_bus.haddr, 32'h104);
        check_val("t4_s_hwrite_replay", s_bus.hwrite, 0);
        check_val("t4_im_hready_pend", im_bus.hready, 0);
        tick();
        s_bus.hrdata = 32'h00000104;
        #2;
        check_val("t4_im_hready_data", im_bus.hready, 1);
        check_val("t4_s_htrans_done", s_bus.htrans, HTRANS_IDLE);
        tick();
        s_bus.hrdata = '0;

        // Two-cycle ERROR response on a dm transfer
        dm_drive(HTRANS_NONSEQ, 32'h600, 1'b1);
        #2;
        check_val("t5_s_haddr", s_bus.haddr, 32'h600);
        check_val("t5_s_hwrite", s_bus.hwrite, 1);
        tick();
        dm_drive(HTRANS_IDLE, 32'h0, 1'b0);
        s_bus.hready = 1'b0;
        s_bus.hresp  = HRESP_ERROR;
        #2;
        check_val("t5_dm_hresp_1", dm_bus.hresp, HRESP_ERROR);
        check_val("t5_dm_hready_1", dm_bus.hready, 0);
        check_val("t5_im_hresp_1", im_bus.hresp, HRESP_OKAY);
        tick();
        s_bus.hready = 1'b1;
        #2;
        check_val("t5_dm_hresp_2", dm_bus.hresp, HRESP_ERROR);
        check_val("t5_dm_hready_2", dm_bus.hready, 1);
        check_val("t5_im_hresp_2", im_bus.hresp, HRESP_OKAY);
        tick();
        s_bus.hresp = HRESP_OKAY;
        #2;
        check_val("t5_dm_hresp_after", dm_bus.hresp, HRESP_OKAY);
        tick();

        // Reset while im is pending
        dm_drive(HTRANS_NONSEQ, 32'h700, 1'b0);
        tick();
        dm_drive(HTRANS_IDLE, 32'h0, 1'b0);
        im_drive(HTRANS_NONSEQ, 32'h100, 1'b0);
        s_bus.hready = 1'b0;
        tick();
        im_drive(HTRANS_IDLE, 32'h0, 1'b0);
        reset = 1'b1;
        #2;
        check_val("t6_im_pending", im_bus.hready, 0);
        tick();
        reset = 1'b0;
        s_bus.hready = 1'b1;
        #2;
        check_val("t6_s_htrans", s_bus.htrans, HTRANS_IDLE);
        check_val("t6_im_hready", im_bus.hready, 1);
        check_val("t6_dm_hready", dm_bus.hready, 1);
        check_val("t6_dm_hresp", dm_bus.hresp, HRESP_OKAY);
        check_val("t6_s_haddr", s_bus.haddr, 0);
        tick();
        #2;
        check_val("t6_no_replay", s_bus.htrans, HTRANS_IDLE);
        check_val("t6_s_haddr_hold", s_bus.haddr, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
